// File: rtl/cc_mem_rd_responder.sv
// Memory-side AXI read responder: accepts AR requests into a small queue and returns
// R-channel bursts (critical-word-first WRAP or linear INCR) from a word-addressed array.
//
// Ports:
//   clk, rst_n         clock (posedge) and synchronous active-low reset
//   araddr_i/arlen_i/arburst_i/arvalid_i/arready_o   AR channel (byte address, beats-1)
//   rdata_o/rresp_o/rlast_o/rvalid_o/rready_i        R channel (64-bit beats)
//   init_wren_i/init_waddr_i/init_wdata_i            backdoor preload port into the array
module cc_mem_rd_responder #(
    parameter int unsigned MEM_AW     = 16,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned ARQ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       araddr_i,
    input  logic [3:0]        arlen_i,
    input  logic [1:0]        arburst_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [63:0]       rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    input  logic              init_wren_i,
    input  logic [MEM_AW-1:0] init_waddr_i,
    input  logic [63:0]       init_wdata_i
);
    localparam int unsigned PtrW     = $clog2(ARQ_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned MemDepth = 1 << MEM_AW;
    localparam logic [3:0]  LatInit  = 4'(RD_LATENCY - 1);
    localparam logic [1:0]  BurstIncr = 2'b01;
    localparam logic [1:0]  BurstWrap = 2'b10;

    typedef struct packed {
        logic [28:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
    } ar_t;

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    // Word address of beat n: WRAP rotates the low bits inside the wrap window,
    // INCR is a plain 29-bit add with the carry dropped.
    function automatic logic [28:0] beat_word(input logic [28:0] a, input logic [3:0] len,
                                              input logic [1:0] burst, input logic [3:0] n);
        logic [28:0] w;
        w = a + {25'd0, n};
        if (burst == BurstWrap) begin
            case (len)
                4'd1:    w = {a[28:1], a[0] ^ n[0]};
                4'd3:    w = {a[28:2], a[1:0] + n[1:0]};
                4'd7:    w = {a[28:3], a[2:0] + n[2:0]};
                4'd15:   w = {a[28:4], a[3:0] + n};
                default: w = a;
            endcase
        end
        return w;
    endfunction

    function automatic logic is_err(input logic [3:0] len, input logic [1:0] burst);
        if (burst == BurstIncr) return 1'b0;
        if (burst == BurstWrap) return !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
        return 1'b1;
    endfunction

    // ---------------- AR queue ----------------
    ar_t             arq_mem [ARQ_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            live_q;
    logic            push, pop, q_empty, q_full;
    ar_t             head;

    assign q_empty   = (count_q == '0);
    assign q_full    = (count_q == CntW'(ARQ_DEPTH));
    // live_q keeps arready low while in reset and for the reset cycle itself
    assign arready_o = live_q & ~q_full;
    assign push      = arvalid_i & arready_o;
    assign head      = arq_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) arq_mem[wr_ptr_q] <= '{addr: araddr_i[31:3], len: arlen_i, burst: arburst_i};
    end

    // ---------------- backing array (not reset) ----------------
    logic [63:0] mem [MemDepth];

    always_ff @(posedge clk) begin
        if (init_wren_i) mem[init_waddr_i] <= init_wdata_i;
    end

    // ---------------- burst FSM ----------------
    state_e      state_q, state_d;
    logic [3:0]  lat_q, beat_q, len_q;
    logic [28:0] addr_q;
    logic [1:0]  burst_q;
    logic        err_q;
    logic [63:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q, rvalid_q;

    logic        r_hs, last_beat, rd_en;
    logic [3:0]  rd_beat;
    logic [28:0] rd_word;
    logic        unused_ok;

    assign r_hs      = rvalid_q & rready_i;
    assign last_beat = (beat_q == len_q);
    assign rd_word   = beat_word(addr_q, len_q, burst_q, rd_beat);
    assign unused_ok = ^{araddr_i[2:0], rd_word};

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!q_empty) state_d = StWait;
            StWait:  if (lat_q == '0) state_d = StBurst;
            StBurst: if (r_hs && last_beat) state_d = q_empty ? StIdle : StWait;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        rd_en   = 1'b0;
        rd_beat = beat_q + 4'd1;
        case (state_q)
            StIdle:  pop = ~q_empty;
            StWait: begin
                rd_en   = (lat_q == '0);
                rd_beat = '0;
            end
            StBurst: begin
                if (r_hs) begin
                    if (last_beat) pop   = ~q_empty;
                    else           rd_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Beat registers: the array read is registered, so a beat reflects the array
    // contents before any same-edge backdoor write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_q    <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            if (pop) begin
                addr_q  <= head.addr;
                len_q   <= head.len;
                burst_q <= head.burst;
                err_q   <= is_err(head.len, head.burst);
                lat_q   <= LatInit;
                beat_q  <= '0;
            end else if (state_q == StWait && lat_q != '0) begin
                lat_q <= lat_q - 4'd1;
            end
            if (rd_en) begin
                beat_q   <= rd_beat;
                rvalid_q <= 1'b1;
                rlast_q  <= (rd_beat == len_q);
                rresp_q  <= err_q ? 2'b10 : 2'b00;
                rdata_q  <= err_q ? '0 : mem[rd_word[MEM_AW-1:0]];
            end else if (r_hs && last_beat) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;
    assign rlast_o  = rlast_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_cc_mem_rd_responder.sv
module tb_cc_mem_rd_responder;
    localparam int unsigned MEM_AW     = 16;
    localparam int unsigned RD_LATENCY = 4;
    localparam int unsigned ARQ_DEPTH  = 4;
    localparam int unsigned MemDepth   = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       araddr_i;
    logic [3:0]        arlen_i;
    logic [1:0]        arburst_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [63:0]       rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i;
    logic              init_wren_i;
    logic [MEM_AW-1:0] init_waddr_i;
    logic [63:0]       init_wdata_i;

    cc_mem_rd_responder #(
        .MEM_AW    (MEM_AW),
        .RD_LATENCY(RD_LATENCY),
        .ARQ_DEPTH (ARQ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .araddr_i    (araddr_i),
        .arlen_i     (arlen_i),
        .arburst_i   (arburst_i),
        .arvalid_i   (arvalid_i),
        .arready_o   (arready_o),
        .rdata_o     (rdata_o),
        .rresp_o     (rresp_o),
        .rlast_o     (rlast_o),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .init_wren_i (init_wren_i),
        .init_waddr_i(init_waddr_i),
        .init_wdata_i(init_wdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
    } ar_t;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    logic [63:0] mm [MemDepth];
    ar_t         ar_pend[$];
    beat_t       exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt, last_cnt, acc_cyc, rise_cyc, gap_cnt;
    int rr_mode = 0;
    bit held = 0, rv_prev = 0, gap_on = 0, gap_armed = 0, saw_full = 0;
    beat_t held_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: beat n of a burst addresses word (w+n) for INCR, and for WRAP the
    // word at offset (w+n) mod size inside the size-aligned window that holds w.
    task automatic push_exp(input ar_t a);
        longint unsigned w, wa, size, base;
        beat_t b;
        bit err;
        w   = longint'(a.addr[31:3]);
        err = (a.burst == 2'b00) || (a.burst == 2'b11) ||
              (a.burst == 2'b10 && !(a.len == 1 || a.len == 3 || a.len == 7 || a.len == 15));
        for (int n = 0; n <= int'(a.len); n++) begin
            if (err) begin
                b.d = '0;
                b.r = 2'b10;
            end else begin
                if (a.burst == 2'b10) begin
                    size = longint'(a.len) + 1;
                    base = w - (w % size);
                    wa   = base + ((w - base + longint'(n)) % size);
                end else begin
                    wa = (w + longint'(n)) % (64'd1 << 29);
                end
                b.d = mm[int'(wa % MemDepth)];
                b.r = 2'b00;
            end
            b.l = (n == int'(a.len));
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_ar();
        if (ar_pend.size() != 0) begin
            arvalid_i = 1'b1;
            araddr_i  = ar_pend[0].addr;
            arlen_i   = ar_pend[0].len;
            arburst_i = ar_pend[0].burst;
        end else begin
            arvalid_i = 1'b0;
        end
    endtask

    task automatic sample();
        beat_t e;
        if (!rst_n) begin
            held    = 0;
            rv_prev = 0;
            return;
        end
        if (arvalid_i && arready_o) begin
            push_exp(ar_pend[0]);
            ar_pend.delete(0);
            acc_cyc = cyc;
        end
        if (!arready_o) saw_full = 1;
        if (held) begin
            chk("hold_valid", 64'(rvalid_o), 64'd1);
            chk("hold_data", rdata_o, held_b.d);
            chk("hold_resp", 64'(rresp_o), 64'(held_b.r));
            chk("hold_last", 64'(rlast_o), 64'(held_b.l));
        end
        held   = rvalid_o && !rready_i;
        held_b = '{d: rdata_o, r: rresp_o, l: rlast_o};
        if (rvalid_o && !rv_prev) begin
            rise_cyc = cyc;
            if (gap_armed) begin
                chk("burst_gap", 64'(gap_cnt), 64'(RD_LATENCY));
                gap_armed = 0;
            end
        end
        if (!rvalid_o) gap_cnt++;
        if (rvalid_o && rready_i) begin
            hs_cnt++;
            if (rlast_o) last_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", rdata_o, e.d);
                chk("rresp", 64'(rresp_o), 64'(e.r));
                chk("rlast", 64'(rlast_o), 64'(e.l));
            end
            if (rlast_o) begin
                gap_cnt = 0;
                if (gap_on) gap_armed = 1;
            end
        end
        rv_prev = rvalid_o;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        sample();
        @(posedge clk);
        #1;
        drive_ar();
        case (rr_mode)
            0:       rready_i = 1'b1;
            1:       rready_i = ~rready_i;
            default: rready_i = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic issue(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        ar_pend.push_back('{addr: addr, len: len, burst: burst});
        drive_ar();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || ar_pend.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size() + ar_pend.size()), 64'd0);
    endtask

    task automatic clr_counts();
        hs_cnt   = 0;
        last_cnt = 0;
    endtask

    initial begin
        logic [28:0] w;
        logic [3:0]  ln;
        logic [1:0]  bu;

        rst_n        = 1'b0;
        arvalid_i    = 1'b0;
        araddr_i     = '0;
        arlen_i      = '0;
        arburst_i    = '0;
        rready_i     = 1'b0;
        init_wren_i  = 1'b0;
        init_waddr_i = '0;
        init_wdata_i = '0;
        clr_counts();
        gap_cnt = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_arready", 64'(arready_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rlast", 64'(rlast_o), 64'd0);
        chk("rst_rresp", 64'(rresp_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_arready", 64'(arready_o), 64'd1);

        // Preload words 0..63
        for (int i = 0; i < 64; i++) begin
            init_wren_i  = 1'b1;
            init_waddr_i = MEM_AW'(i);
            init_wdata_i = 64'hA5A5_0000_0000_0000 | 64'(i);
            mm[i]        = init_wdata_i;
            tick();
        end
        init_wren_i = 1'b0;

        // WRAP len7 at 0x18, rready held high, plus first-beat latency
        rr_mode = 0;
        clr_counts();
        rise_cyc = -1;
        issue(32'h0000_0018, 4'd7, 2'b10);
        drain("wrap_basic");
        chk("first_rvalid_latency", 64'(rise_cyc - acc_cyc), 64'(RD_LATENCY + 2));
        chk("wrap_basic_hs", 64'(hs_cnt), 64'd8);
        chk("wrap_basic_last", 64'(last_cnt), 64'd1);

        // Same burst with rready toggling
        rr_mode  = 1;
        rready_i = 1'b0;
        clr_counts();
        issue(32'h0000_0018, 4'd7, 2'b10);
        drain("wrap_toggle");
        chk("wrap_toggle_hs", 64'(hs_cnt), 64'd8);
        chk("wrap_toggle_last", 64'(last_cnt), 64'd1);

        // Five ARs back to back: queue fills, bursts in order with a latency gap
        rr_mode  = 0;
        saw_full = 0;
        gap_on   = 1;
        clr_counts();
        for (int k = 0; k < 5; k++)
            issue(32'(k * 64 + k * 8), 4'd7, 2'b10);
        drain("five_ar");
        gap_on    = 0;
        gap_armed = 0;
        chk("five_ar_full_seen", 64'(saw_full), 64'd1);
        chk("five_ar_hs", 64'(hs_cnt), 64'd40);
        chk("five_ar_last", 64'(last_cnt), 64'd5);

        // INCR crossing a line
        clr_counts();
        issue(32'h0000_0038, 4'd7, 2'b01);
        drain("incr");
        chk("incr_hs", 64'(hs_cnt), 64'd8);

        // Illegal burst type: SLVERR beats
        clr_counts();
        issue(32'h0000_0020, 4'd3, 2'b00);
        drain("slverr");
        chk("slverr_hs", 64'(hs_cnt), 64'd4);
        chk("slverr_last", 64'(last_cnt), 64'd1);

        // Randomized requests with random backpressure
        rr_mode = 2;
        for (int k = 0; k < 24; k++) begin
            bu = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) ln = 4'(1 << $urandom_range(1, 4)) - 4'd1;
            else                           ln = 4'($urandom_range(0, 15));
            w = {13'($urandom), 10'd0, 6'((bu == 2'b01) ? $urandom_range(0, 48) : $urandom_range(0, 63))};
            issue({w, 3'($urandom)}, ln, bu);
        end
        drain("random");

        // Reset during beat 3
        rr_mode = 0;
        clr_counts();
        issue(32'h0000_0010, 4'd7, 2'b10);
        for (int k = 0; k < 200 && hs_cnt < 2; k++) tick();
        chk("rst_mid_hs", 64'(hs_cnt), 64'd2);
        chk("rst_mid_pre_valid", 64'(rvalid_o), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        ar_pend.delete();
        tick();
        chk("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_mid_arready", 64'(arready_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        clr_counts();
        issue(32'h0000_0028, 4'd7, 2'b10);
        drain("after_rst");
        chk("after_rst_hs", 64'(hs_cnt), 64'd8);
        chk("after_rst_last", 64'(last_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
